lzc_seq: RTL
============

Name: lzc_seq

Overview:
- Multi-cycle, handshaked leading-zero counter for the reciprocal/normalisation path. It is the parametrised successor to the combinational casez LZC.
- Scans the operand CHUNK bits per cycle, MSB first, and stops early at the first set bit.
- Returns the zero count, a zero flag and, optionally, the left-normalised operand.
- Trades latency for area, replacing the fixed-width flat priority encoder on wide operands.

Parameters:
- WIDTH, 24, operand width in bits; legal range 1..64.
- CHUNK, 4, bits examined per scan cycle; legal range 1..WIDTH; need not divide WIDTH.
- NCHUNK (localparam), ceil(WIDTH/CHUNK), maximum number of scan cycles.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- i_valid  input  1  operand offered.
- o_ready  output  1  block can accept an operand this cycle.
- i_data  input  WIDTH  operand; sampled only on an accept.
- o_valid  output  1  result available.
- i_ready  input  1  consumer takes the result this cycle.
- o_cnt  output  7  leading-zero count, 0..WIDTH.
- o_zero  output  1  operand was all zeros.
- o_norm  output  WIDTH  i_data << o_cnt (feature-dependent, see Optional Feature).

Behaviour:
- Reset (reset_n low at an edge):
  - state=IDLE; o_valid=0; o_cnt=0; o_zero=0; o_norm=0.
  - Internal shift register and chunk counter cleared.
  - A reset during SCAN or DONE aborts the operation; no result is emitted.
- States:
  - IDLE: o_ready=1, o_valid=0.
  - SCAN: o_ready=0, o_valid=0.
  - DONE: o_valid=1; o_ready=i_ready (combinational).
- Accept (o_ready & i_valid at an edge):
  - Load the shift register with i_data.
  - Clear the count accumulator and the chunk index.
  - Go to SCAN.
- SCAN, one chunk per edge:
  - Examine the top CHUNK bits of the shift register.
  - For the final partial chunk, missing LSBs are treated as 0.
  - Top chunk nonzero:
    - count += leading zeros within the chunk.
    - Register shifted left by that amount.
    - Go to DONE.
  - Top chunk zero:
    - count += CHUNK.
    - Register shifted left by CHUNK; chunk index increments.
    - If this was chunk NCHUNK-1, go to DONE with count clamped to WIDTH and o_zero=1.
- Latency: o_valid rises k cycles after the accepting edge, where k = 1-based index of the chunk holding the MSB set bit. All-zero input gives k=NCHUNK.
- DONE:
  - o_cnt, o_zero and o_norm are registered and held stable while o_valid & !i_ready.
  - i_ready & !i_valid: go to IDLE.
  - i_ready & i_valid: the result is consumed and a new operand is accepted on the same edge (back-to-back, straight to SCAN).
- i_valid while not o_ready is ignored. i_data need not be held after the accept.
- o_cnt width is fixed at 7 bits. The value never exceeds WIDTH.

Optional Feature:
- Macro: LZC_SEQ_NORM_EN.
- Defined:
  - o_norm = normalised operand (MSB set unless zero); zero input gives o_norm=0.
  - The final intra-chunk shift is implemented.
- Undefined:
  - o_norm is tied to 0.
  - The shift register shifts only by whole chunks, and the intra-chunk shifter is omitted.
  - o_cnt, o_zero, timing and handshake are identical to the defined case.

Test Plan (WIDTH=24, CHUNK=4 unless stated):
- 0x800000 accepted -> o_valid 1 cycle later; o_cnt=0, o_zero=0, o_norm=0x800000.
- 0x00F000 -> o_valid after 3 cycles; o_cnt=8, o_norm=0xF00000.
- 0x000001 -> 6 cycles, o_cnt=23, o_norm=0x800000.
- 0x000000 -> 6 cycles, o_cnt=24, o_zero=1, o_norm=0.
- Backpressure then back-to-back:
  - Hold i_ready=0 for 5 cycles on result 0x00F000; outputs stay constant, o_ready=0.
  - Then i_ready=1 with i_valid=1, i_data=0x012345 -> accepted on the same edge.
  - Result after 2 cycles: o_cnt=7, o_norm=0x91A280.
- Reset and partial chunk:
  - Assert reset_n=0 on the 3rd SCAN cycle of 0x000001 -> next cycle o_valid=0, o_ready=1, o_cnt=0.
  - Separately, WIDTH=20, CHUNK=8, data 0x00001 -> 3 cycles, o_cnt=19.
  - Repeat all cases with LZC_SEQ_NORM_EN undefined: o_norm=0, counts and timing unchanged.

Source files
------------

// File: rtl/lzc_seq.sv
// Multi-cycle handshaked leading-zero counter: scans CHUNK bits per cycle, MSB first.
// Define LZC_SEQ_NORM_EN to produce the left-normalised operand on o_norm.
module lzc_seq #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [6:0]       o_cnt,
  output logic             o_zero,
  output logic [WIDTH-1:0] o_norm
);

  localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [6:0]       acc_q;
  logic [6:0]       idx_q;
  logic [6:0]       cnt_q;
  logic             zero_q;
  logic [CHUNK-1:0] top;
  logic [6:0]       lz;
  logic [6:0]       acc_next;
  logic             accept;

  // Leading zeros of a nonzero chunk; the highest set bit wins.
  function automatic logic [6:0] chunk_lz(input logic [CHUNK-1:0] c);
    logic [6:0] r;
    r = 7'(CHUNK);
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (c[i]) r = 7'(int'(CHUNK) - 1 - i);
    end
    return r;
  endfunction

  // Bits shifted in from the right are zero, so a partial last chunk is zero-padded.
  always_comb begin
    top      = sr_q[WIDTH-1 -: CHUNK];
    lz       = chunk_lz(top);
    acc_next = acc_q + 7'(CHUNK);
  end

  always_comb begin
    o_ready = 1'b0;
    unique case (state_q)
      StIdle:  o_ready = 1'b1;
      StScan:  o_ready = 1'b0;
      StDone:  o_ready = i_ready;
      default: o_ready = 1'b0;
    endcase
  end

  assign accept  = o_ready & i_valid;
  assign o_valid = (state_q == StDone);
  assign o_cnt   = cnt_q;
  assign o_zero  = zero_q;

`ifdef LZC_SEQ_NORM_EN
  logic [WIDTH-1:0] norm_q;
  assign o_norm = norm_q;
`else
  assign o_norm = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
`ifdef LZC_SEQ_NORM_EN
      norm_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            sr_q    <= i_data;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (top != '0) begin
            cnt_q   <= acc_q + lz;
            zero_q  <= 1'b0;
            state_q <= StDone;
`ifdef LZC_SEQ_NORM_EN
            sr_q    <= sr_q << lz;
            norm_q  <= sr_q << lz;
`endif
          end else begin
            acc_q <= acc_next;
            sr_q  <= sr_q << CHUNK;
            idx_q <= idx_q + 7'd1;
            if (idx_q == 7'(NCHUNK - 1)) begin
              // Padding bits of a partial last chunk would overcount; clamp.
              cnt_q   <= (acc_next > 7'(WIDTH)) ? 7'(WIDTH) : acc_next;
              zero_q  <= 1'b1;
              state_q <= StDone;
`ifdef LZC_SEQ_NORM_EN
              norm_q  <= '0;
`endif
            end
          end
        end
        StDone: begin
          if (i_ready) begin
            if (i_valid) begin
              sr_q    <= i_data;
              acc_q   <= '0;
              idx_q   <= '0;
              state_q <= StScan;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
